// File: rtl/booth_sched_pkg.sv
// booth_pkg: shared types and constants for the booth_sched slice.
//   state_e  : sequencer state encoding
//   Q_ADD    : Booth pair {Q0,Q-1} that requests A <= A + M
//   Q_SUB    : Booth pair {Q0,Q-1} that requests A <= A - M
//   WIDTH_DEF: default operand width / iteration count
package booth_pkg;

  localparam int unsigned WIDTH_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b000,
    ST_LOAD  = 3'b001,
    ST_EVAL  = 3'b010,
    ST_SHIFT = 3'b011,
    ST_DONE  = 3'b100
  } state_e;

  localparam logic [1:0] Q_ADD = 2'b01;
  localparam logic [1:0] Q_SUB = 2'b10;

endpackage

// File: rtl/booth_sched_if.sv
// booth_sched_if: bundle between the requesters, the Booth datapath and
// the scheduler.
//   req   : per-requester request level (bit 0 = requester 0)
//   q     : Booth bit pair {Q0, Q-1} from the datapath
//   gnt   : one-hot grant
//   sel   : operand mux select
//   load/suma/resta/desp : datapath strobes
//   done  : per-requester completion pulse
//   busy  : scheduler not idle
//   abort : aborted-operation pulse (only with BOOTH_SCHED_ABORT_EN)
// master = requester/datapath side, slave = scheduler side.
interface booth_sched_if;
  logic [1:0] req;
  logic [1:0] q;
  logic [1:0] gnt;
  logic       sel;
  logic       load;
  logic       suma;
  logic       resta;
  logic       desp;
  logic [1:0] done;
  logic       busy;
`ifdef BOOTH_SCHED_ABORT_EN
  logic       abort;

  modport master (output req, q,
                  input  gnt, sel, load, suma, resta, desp, done, busy, abort);
  modport slave  (input  req, q,
                  output gnt, sel, load, suma, resta, desp, done, busy, abort);
`else
  modport master (output req, q,
                  input  gnt, sel, load, suma, resta, desp, done, busy);
  modport slave  (input  req, q,
                  output gnt, sel, load, suma, resta, desp, done, busy);
`endif
endinterface

// File: rtl/booth_sched_rr_arb.sv
// booth_rr_arb: two-way round-robin winner selection.
//   clk, rst_n : clock, async active-low reset
//   req        : request levels
//   upd_en     : record upd_idx as last served (driven in LOAD)
//   upd_idx    : index of the requester being served
//   win        : winning requester index (valid when req != 0)
//   lp         : last-served pointer, resets to 1 so requester 0 wins first
module booth_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       upd_en,
  input  logic       upd_idx,
  output logic       win,
  output logic       lp
);

  logic lp_q, lp_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lp_q <= 1'b1;
    else        lp_q <= lp_d;
  end

  always_comb begin
    lp_d = lp_q;
    if (upd_en) lp_d = upd_idx;
  end

  always_comb begin
    unique case (req)
      2'b11:   win = ~lp_q;
      2'b10:   win = 1'b1;
      default: win = 1'b0;
    endcase
  end

  assign lp = lp_q;

endmodule

// File: rtl/booth_sched.sv
// booth_sched: sequencer and round-robin arbiter for a shared radix-2
// Booth multiplier datapath.
//   clk, rst_n : clock, async active-low reset
//   bus        : booth_sched_if.slave (req, q in; gnt, sel, load, suma,
//                resta, desp, done, busy out; abort out when enabled)
//   WIDTH      : operand width = iteration count (>= 2)
// Optional feature macro: BOOTH_SCHED_ABORT_EN (granted requester dropping
// req mid-operation returns to IDLE without done and pulses abort).
module booth_sched
  import booth_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  booth_sched_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sel_q, sel_d;
  logic          win;
  logic          lp;
  logic          last_iter;

  booth_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.req),
    .upd_en  (state_q == ST_LOAD),
    .upd_idx (sel_q),
    .win     (win),
    .lp      (lp)
  );

`ifdef BOOTH_SCHED_ABORT_EN
  logic abort_q, abort_d;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
`ifdef BOOTH_SCHED_ABORT_EN
      abort_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
`ifdef BOOTH_SCHED_ABORT_EN
      abort_q <= abort_d;
`endif
    end
  end

  // Exit test uses cnt before the decrement
  assign last_iter = (cnt_q == CW'(1));

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
`ifdef BOOTH_SCHED_ABORT_EN
    abort_d = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          sel_d   = win;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = CW'(WIDTH);
        state_d = ST_EVAL;
      end
      ST_EVAL: begin
        if (bus.q == Q_ADD || bus.q == Q_SUB) begin
          state_d = ST_SHIFT;
        end else begin
          cnt_d   = cnt_q - CW'(1);
          state_d = last_iter ? ST_DONE : ST_EVAL;
        end
      end
      ST_SHIFT: begin
        cnt_d   = cnt_q - CW'(1);
        state_d = last_iter ? ST_DONE : ST_EVAL;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
`ifdef BOOTH_SCHED_ABORT_EN
    // lp already recorded this requester in LOAD, so it stays last-served.
    if ((state_q == ST_LOAD || state_q == ST_EVAL || state_q == ST_SHIFT) &&
        !bus.req[sel_q]) begin
      state_d = ST_IDLE;
      abort_d = 1'b1;
    end
`endif
  end

  // Output decode: Moore except the EVAL strobes, which follow q
  always_comb begin
    bus.gnt   = '0;
    bus.done  = '0;
    bus.load  = 1'b0;
    bus.suma  = 1'b0;
    bus.resta = 1'b0;
    bus.desp  = 1'b0;
    bus.busy  = (state_q != ST_IDLE);
    bus.sel   = sel_q;
    if (state_q != ST_IDLE) bus.gnt[sel_q] = 1'b1;
    unique case (state_q)
      ST_LOAD:  bus.load = 1'b1;
      ST_EVAL: begin
        bus.suma  = (bus.q == Q_ADD);
        bus.resta = (bus.q == Q_SUB);
        bus.desp  = !(bus.q == Q_ADD || bus.q == Q_SUB);
      end
      ST_SHIFT: bus.desp = 1'b1;
      ST_DONE:  bus.done[sel_q] = 1'b1;
      default: ;
    endcase
  end

`ifdef BOOTH_SCHED_ABORT_EN
  assign bus.abort = abort_q;
`endif

endmodule

// File: doc/booth_sched.md
# booth_sched

Sequencer and two-way arbiter for the shared radix-2 Booth multiplier datapath. It grants the datapath to one of two requesters in round-robin order and issues the load, add, subtract and shift strobes for WIDTH iterations. It reads the Booth bit pair from the datapath and returns a per-requester done pulse. It sits between the requesting units and the datapath and replaces per-requester control units.

## Interface
- WIDTH, default 4: operand width, which is also the iteration count; the minimum is 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  2  request per requester (bit 0 = requester 0); level, held until done.
- q  in  2  Booth bit pair {Q0, Q-1} from the datapath, valid every cycle.
- gnt  out  2  one-hot grant; high from LOAD through DONE inclusive.
- sel  out  1  operand mux select to the datapath (0 = requester 0); stable while busy.
- load  out  1  loads the operands and clears A / Q-1 in the datapath.
- suma  out  1  A <= A + M this cycle.
- resta  out  1  A <= A - M this cycle.
- desp  out  1  arithmetic right shift of {A, Q, Q-1} this cycle.
- done  out  2  one-cycle pulse to the granted requester; the product is valid in the datapath in the same cycle.
- busy  out  1  high in any state other than IDLE.

## Operation
- States:
  - IDLE: arbitrates.
  - LOAD: asserts load.
  - EVAL: asserts suma, resta or desp.
  - SHIFT: asserts desp.
  - DONE: asserts done[sel].
- IDLE: if no req, stay. Otherwise select a winner, latch sel, set gnt, go to LOAD.
- Round-robin: the last-served pointer lp resets to 1, so requester 0 wins the first tie. When both requesters request, the one that is not lp wins. When one requests, it wins. lp updates at LOAD.
- LOAD: load=1, iteration counter cnt <= WIDTH, go to EVAL.
- EVAL:
  - q=01: suma=1, go to SHIFT.
  - q=10: resta=1, go to SHIFT.
  - q=00 or 11: desp=1 in the same cycle and cnt decrements. If cnt was 1, go to DONE, else stay in EVAL.
- SHIFT: desp=1, cnt decrements. If cnt was 1, go to DONE, else go to EVAL.
- DONE: done[sel]=1, gnt held, go to IDLE unconditionally.
- Arbitration happens only in IDLE. A req that is still high after done is treated as a new request.
- Signal exclusivity: at most one of load, suma, resta, desp is high in any cycle; suma and resta are never both high.
- Counter: cnt is $clog2(WIDTH+1) bits and never wraps. The EVAL/SHIFT exit condition is evaluated on cnt==1 before the decrement.
- A req change by a non-granted requester while busy has no effect until IDLE.

## Timing
- All outputs are registered-state decodes, Moore except the EVAL strobes, which depend combinationally on q.
- Reset values: state=IDLE, lp=1, cnt=0, sel=0. gnt, load, suma, resta, desp, done and busy are all 0.
- Reset mid-operation: state clears immediately and asynchronously; no done is issued and the requester must re-request.
- Latency from a winning req sampled in IDLE to the done pulse: 1 (IDLE→LOAD) + 1 (LOAD) + WIDTH + k cycles, where k is the number of EVAL cycles with q in {01, 10}.
- The minimum gap between consecutive operations is one IDLE cycle after DONE.

## Configuration
- BOOTH_SCHED_ABORT_EN defined:
  - If the granted requester drops req while in LOAD, EVAL or SHIFT, the next state is IDLE.
  - No done is issued for an aborted operation.
  - lp keeps the aborted requester as last-served.
  - An extra output abort (1 bit, reset 0) pulses for one cycle on that transition.
- BOOTH_SCHED_ABORT_EN undefined:
  - A req drop while busy is ignored; the operation completes and done pulses.
  - No abort port exists.

## Structure
- Package booth_pkg holds:
  - the state typedef, encoded 3'b000 IDLE, 001 LOAD, 010 EVAL, 011 SHIFT, 100 DONE;
  - the Booth pair constants Q_ADD=2'b01, Q_SUB=2'b10;
  - the default WIDTH.
- Sub-module booth_rr_arb: two-way round-robin winner and lp pointer, with an update enable driven at LOAD.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, with req=11 → all outputs 0 and busy=0. Release → gnt=01 at the first LOAD.
- WIDTH=4, req=01, q held 00 → load for 1 cycle, then 4 cycles of desp, then done=01 exactly 6 cycles after LOAD begins.
- WIDTH=4, req=10, q held 10 → resta/desp alternate 4 times, done=10 on the 10th cycle after LOAD, and suma is never high.
- req=11 from reset → requester 0 served first. After one IDLE cycle gnt=10, then, with req still 11, gnt=01 again (alternation).
- Drive rst_n=0 asynchronously in EVAL with q=01 → suma, gnt and busy drop within the same cycle, and no done follows.
- With BOOTH_SCHED_ABORT_EN, drop req[0] in the second EVAL → abort pulses once, state returns to IDLE, done stays 00, and a pending req[1] is granted next.
